// File: rtl/uart_rx_status_pkg.sv
// Shared constants for the UART receive status/interrupt block:
// FIFO geometry, record layout, LSR bit positions, IIR codes and RX trigger encodings.
package uart_rx_status_pkg;

  localparam int UART_FIFO_COUNTER_W = 5;
  localparam int UART_FIFO_REC_WIDTH = 11;

  // Record layout is {data[7:0], break, parity_err, framing_err}
  localparam int REC_FE = 0;
  localparam int REC_PE = 1;
  localparam int REC_BI = 2;

  localparam int LSR_DR   = 0;
  localparam int LSR_OE   = 1;
  localparam int LSR_PE   = 2;
  localparam int LSR_FE   = 3;
  localparam int LSR_BI   = 4;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
  localparam int LSR_EI   = 7;

  localparam int IER_ERBFI = 0;
  localparam int IER_ELSI  = 1;

  localparam logic [3:0] IIR_NONE = 4'b0001;
  localparam logic [3:0] IIR_RLS  = 4'b0110;
  localparam logic [3:0] IIR_RDA  = 4'b0100;
  localparam logic [3:0] IIR_TI   = 4'b1100;

  typedef enum logic [1:0] {
    TRIG_1  = 2'b00,
    TRIG_4  = 2'b01,
    TRIG_8  = 2'b10,
    TRIG_14 = 2'b11
  } rx_trig_e;

  function automatic logic [4:0] trig_level(input rx_trig_e trig);
    case (trig)
      TRIG_1:  return 5'd1;
      TRIG_4:  return 5'd4;
      TRIG_8:  return 5'd8;
      default: return 5'd14;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_status_sticky_bit.sv
// Sticky status flag with synchronous clear and async reset.
// A set in the same cycle as a clear wins, so an error event is never dropped.
module uart_sticky_bit (
  input  logic clk,
  input  logic wb_rst_i,
  input  logic set,
  input  logic clr,
  output logic q
);

  logic flag_d;
  logic flag_q;

  always_comb begin
    flag_d = flag_q;
    if (clr) flag_d = 1'b0;
    if (set) flag_d = 1'b1;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) flag_q <= 1'b0;
    else          flag_q <= flag_d;
  end

  assign q = flag_q;

endmodule

// File: rtl/uart_rx_status.sv
// Receive-side line status and interrupt generation downstream of the RX FIFO.
// Produces LSR, RX interrupt requests, the IIR code, the FIFO pop strobe and lsr_mask.
module uart_rx_status
  import uart_rx_status_pkg::*;
#(
  parameter int FIFO_CW = UART_FIFO_COUNTER_W,
  parameter int REC_W   = UART_FIFO_REC_WIDTH
) (
  input  logic               clk,
  input  logic               wb_rst_i,
  input  logic [FIFO_CW-1:0] rf_count,
  input  logic [REC_W-1:0]   rf_data_out,
  input  logic               rf_overrun,
  input  logic               rf_error_bit,
  input  logic [9:0]         counter_t,
  input  logic [1:0]         fcr_trig,
  input  logic [1:0]         ier,
  input  logic               thr_empty,
  input  logic               tx_empty,
  input  logic               lsr_read,
  input  logic               rbr_read,
  output logic               rf_pop,
  output logic               lsr_mask,
  output logic [7:0]         lsr,
  output logic               rda_int,
  output logic               ti_int,
  output logic               ls_int,
  output logic [3:0]         iir_id
);

  logic               cnt_nz;
  logic [FIFO_CW-1:0] trig_lvl;
  logic               top_new;
  logic               oe_set, pe_set, fe_set, bi_set;
  logic               oe_flag, pe_flag, fe_flag, bi_flag;

  logic       cnt_nz_d,    cnt_nz_q;
  logic       top_first_d, top_first_q;
  logic       pop_seen_d,  pop_seen_q;
  logic       rf_pop_d,    rf_pop_q;
  logic       lsr_mask_d,  lsr_mask_q;
  logic       overrun_d,   overrun_q;
  logic       rda_int_d,   rda_int_q;
  logic       ti_int_d,    ti_int_q;
  logic [3:0] iir_id_d,    iir_id_q;

  logic unused_rec_data;
  assign unused_rec_data = ^rf_data_out[REC_W-1:3];

  always_comb begin
    cnt_nz   = (rf_count != '0);
    trig_lvl = FIFO_CW'(trig_level(rx_trig_e'(fcr_trig)));

    cnt_nz_d    = cnt_nz;
    top_first_d = cnt_nz & ~cnt_nz_q;
    pop_seen_d  = rf_pop_q;
    // A fresh record reaches the top either when the FIFO leaves empty or after a pop
    top_new     = top_first_q | (pop_seen_q & cnt_nz);

    rf_pop_d   = rbr_read & cnt_nz;
    lsr_mask_d = lsr_read;
    overrun_d  = rf_overrun;

    oe_set = rf_overrun & ~overrun_q;
    pe_set = top_new & rf_data_out[REC_PE];
    fe_set = top_new & rf_data_out[REC_FE];
    bi_set = top_new & rf_data_out[REC_BI];

    rda_int_d = ier[IER_ERBFI] & (rf_count >= trig_lvl);
    // Timeout holds until the host reads RBR or the FIFO drains
    ti_int_d  = ier[IER_ERBFI] & cnt_nz & ~rbr_read & (ti_int_q | (counter_t == '0));

    lsr           = '0;
    lsr[LSR_DR]   = cnt_nz_q;
    lsr[LSR_OE]   = oe_flag;
    lsr[LSR_PE]   = pe_flag;
    lsr[LSR_FE]   = fe_flag;
    lsr[LSR_BI]   = bi_flag;
    lsr[LSR_THRE] = thr_empty;
    lsr[LSR_TEMT] = tx_empty;
    lsr[LSR_EI]   = rf_error_bit & cnt_nz_q;

    ls_int = ier[IER_ELSI] & (oe_flag | pe_flag | fe_flag | bi_flag);

    iir_id_d = IIR_NONE;
    if (ls_int)         iir_id_d = IIR_RLS;
    else if (rda_int_q) iir_id_d = IIR_RDA;
    else if (ti_int_q)  iir_id_d = IIR_TI;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cnt_nz_q    <= 1'b0;
      top_first_q <= 1'b0;
      pop_seen_q  <= 1'b0;
      rf_pop_q    <= 1'b0;
      lsr_mask_q  <= 1'b0;
      overrun_q   <= 1'b0;
      rda_int_q   <= 1'b0;
      ti_int_q    <= 1'b0;
      iir_id_q    <= IIR_NONE;
    end else begin
      cnt_nz_q    <= cnt_nz_d;
      top_first_q <= top_first_d;
      pop_seen_q  <= pop_seen_d;
      rf_pop_q    <= rf_pop_d;
      lsr_mask_q  <= lsr_mask_d;
      overrun_q   <= overrun_d;
      rda_int_q   <= rda_int_d;
      ti_int_q    <= ti_int_d;
      iir_id_q    <= iir_id_d;
    end
  end

  uart_sticky_bit u_oe (.clk(clk), .wb_rst_i(wb_rst_i), .set(oe_set), .clr(lsr_read), .q(oe_flag));
  uart_sticky_bit u_pe (.clk(clk), .wb_rst_i(wb_rst_i), .set(pe_set), .clr(lsr_read), .q(pe_flag));
  uart_sticky_bit u_fe (.clk(clk), .wb_rst_i(wb_rst_i), .set(fe_set), .clr(lsr_read), .q(fe_flag));
  uart_sticky_bit u_bi (.clk(clk), .wb_rst_i(wb_rst_i), .set(bi_set), .clr(lsr_read), .q(bi_flag));

  assign rf_pop   = rf_pop_q;
  assign lsr_mask = lsr_mask_q;
  assign rda_int  = rda_int_q;
  assign ti_int   = ti_int_q;
  assign iir_id   = iir_id_q;

endmodule

// File: tb/tb_uart_rx_status.sv
// Bench for uart_rx_status: a small FIFO model feeds count/top record, pops follow rf_pop,
// and expected pop pulses are queued at each rbr_read strobe and compared one cycle later.
module tb_uart_rx_status;
  import uart_rx_status_pkg::*;

  localparam int CW = 5;
  localparam int RW = 11;

  logic          clk = 1'b0;
  logic          wb_rst_i;
  logic [CW-1:0] rf_count;
  logic [RW-1:0] rf_data_out;
  logic          rf_overrun, rf_error_bit;
  logic [9:0]    counter_t;
  logic [1:0]    fcr_trig, ier;
  logic          thr_empty, tx_empty, lsr_read, rbr_read;
  logic          rf_pop, lsr_mask, rda_int, ti_int, ls_int;
  logic [7:0]    lsr;
  logic [3:0]    iir_id;

  int n_checks = 0;
  int n_errors = 0;

  logic [RW-1:0] fifo[$];
  logic          exp_pop[$];

  always #5 clk = ~clk;

  uart_rx_status #(.FIFO_CW(CW), .REC_W(RW)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .rf_count(rf_count), .rf_data_out(rf_data_out),
    .rf_overrun(rf_overrun), .rf_error_bit(rf_error_bit), .counter_t(counter_t),
    .fcr_trig(fcr_trig), .ier(ier), .thr_empty(thr_empty), .tx_empty(tx_empty),
    .lsr_read(lsr_read), .rbr_read(rbr_read), .rf_pop(rf_pop), .lsr_mask(lsr_mask),
    .lsr(lsr), .rda_int(rda_int), .ti_int(ti_int), .ls_int(ls_int), .iir_id(iir_id)
  );

  task automatic sync_fifo();
    rf_count = CW'(fifo.size());
    if (fifo.size() != 0) rf_data_out = fifo[0];
    else                  rf_data_out = '0;
  endtask

  // One clock; the FIFO model drops its head when rf_pop was high during the cycle
  task automatic tick();
    logic p;
    p = rf_pop;
    @(posedge clk);
    #1;
    if (p === 1'b1 && fifo.size() != 0) fifo.delete(0);
    sync_fifo();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (fifo.size() != 0 && guard < 40) begin
      rbr_read = 1'b1; tick();
      rbr_read = 1'b0; tick();
      guard++;
    end
    tick(); tick();
    n_checks++;
    if (fifo.size() != 0) begin
      n_errors++; $display("FAIL drain: fifo entries left %0d expected 0", fifo.size());
    end
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; rf_overrun = 1'b0; rf_error_bit = 1'b1; counter_t = '1;
    fcr_trig = 2'b00; ier = 2'b00; thr_empty = 1'b1; tx_empty = 1'b0;
    lsr_read = 1'b0; rbr_read = 1'b0;
    fifo.delete(); sync_fifo();
    tick(); tick();
    n_checks++; if (lsr !== 8'h20) begin n_errors++; $display("FAIL reset_lsr: got %h expected 20", lsr); end
    n_checks++; if ({rf_pop, lsr_mask} !== 2'b00) begin n_errors++; $display("FAIL reset_pulses: got %b expected 00", {rf_pop, lsr_mask}); end
    n_checks++; if ({rda_int, ti_int, ls_int} !== 3'b000) begin n_errors++; $display("FAIL reset_ints: got %b expected 000", {rda_int, ti_int, ls_int}); end
    n_checks++; if (iir_id !== IIR_NONE) begin n_errors++; $display("FAIL reset_iir: got %b expected 0001", iir_id); end
    wb_rst_i = 1'b0; rf_error_bit = 1'b0;
    tick();
  endtask

  task automatic test_data_ready();
    logic e;
    ier = 2'b01; fcr_trig = 2'b00; counter_t = '1;
    fifo.push_back({8'h41, 3'b000}); sync_fifo();
    tick();
    n_checks++; if (lsr !== 8'h21) begin n_errors++; $display("FAIL dr_set: got %h expected 21", lsr); end
    n_checks++; if (rda_int !== 1'b1) begin n_errors++; $display("FAIL rda_set: got %b expected 1", rda_int); end
    tick();
    n_checks++; if (iir_id !== IIR_RDA) begin n_errors++; $display("FAIL iir_rda: got %b expected 0100", iir_id); end
    rbr_read = 1'b1; exp_pop.push_back(rbr_read && fifo.size() != 0);
    tick(); rbr_read = 1'b0;
    e = exp_pop.pop_front();
    n_checks++; if (rf_pop !== e) begin n_errors++; $display("FAIL pop_pulse: got %b expected %b", rf_pop, e); end
    exp_pop.push_back(rbr_read && fifo.size() != 0);
    tick();
    e = exp_pop.pop_front();
    n_checks++; if (rf_pop !== e) begin n_errors++; $display("FAIL pop_single: got %b expected %b", rf_pop, e); end
    tick();
    n_checks++; if (lsr !== 8'h20 || rda_int !== 1'b0) begin n_errors++; $display("FAIL dr_clear: got lsr %h rda %b expected 20 0", lsr, rda_int); end
  endtask

  task automatic test_line_status();
    ier = 2'b11; rf_error_bit = 1'b1;
    fifo.push_back({8'h00, 3'b100}); sync_fifo();
    tick();
    n_checks++; if (lsr[LSR_BI] !== 1'b0) begin n_errors++; $display("FAIL bi_latency: got %b expected 0", lsr[LSR_BI]); end
    tick();
    n_checks++; if (lsr !== 8'hB1) begin n_errors++; $display("FAIL bi_set: got %h expected b1", lsr); end
    n_checks++; if (ls_int !== 1'b1) begin n_errors++; $display("FAIL ls_int_set: got %b expected 1", ls_int); end
    tick();
    n_checks++; if (iir_id !== IIR_RLS) begin n_errors++; $display("FAIL iir_rls: got %b expected 0110", iir_id); end
    lsr_read = 1'b1; tick(); lsr_read = 1'b0;
    n_checks++; if (lsr !== 8'hA1) begin n_errors++; $display("FAIL bi_clear: got %h expected a1", lsr); end
    n_checks++; if (lsr_mask !== 1'b1 || ls_int !== 1'b0) begin n_errors++; $display("FAIL mask_pulse: got mask %b ls %b expected 1 0", lsr_mask, ls_int); end
    tick();
    n_checks++; if (lsr_mask !== 1'b0) begin n_errors++; $display("FAIL mask_single: got %b expected 0", lsr_mask); end
    n_checks++; if (iir_id !== IIR_RDA) begin n_errors++; $display("FAIL iir_after_ls: got %b expected 0100", iir_id); end
    rf_error_bit = 1'b0;
    drain();
  endtask

  task automatic test_trigger();
    ier = 2'b01; fcr_trig = 2'b10;
    for (int i = 0; i < 7; i++) fifo.push_back({8'(i), 3'b000});
    sync_fifo(); tick(); tick();
    n_checks++; if (rda_int !== 1'b0) begin n_errors++; $display("FAIL trig8_at7: got %b expected 0", rda_int); end
    fifo.push_back({8'h07, 3'b000}); sync_fifo(); tick();
    n_checks++; if (rda_int !== 1'b1) begin n_errors++; $display("FAIL trig8_at8: got %b expected 1", rda_int); end
    fcr_trig = 2'b11;
    for (int i = 0; i < 5; i++) fifo.push_back({8'(i + 8), 3'b000});
    sync_fifo(); tick();
    n_checks++; if (rda_int !== 1'b0) begin n_errors++; $display("FAIL trig14_at13: got %b expected 0", rda_int); end
    fifo.push_back({8'h0d, 3'b000}); sync_fifo(); tick();
    n_checks++; if (rda_int !== 1'b1) begin n_errors++; $display("FAIL trig14_at14: got %b expected 1", rda_int); end
    fifo.push_back({8'h0e, 3'b000}); fifo.push_back({8'h0f, 3'b000}); sync_fifo(); tick(); tick();
    n_checks++; if (rda_int !== 1'b1 || rf_count !== 5'd16) begin n_errors++; $display("FAIL trig14_full: got rda %b count %0d expected 1 16", rda_int, rf_count); end
    drain();
  endtask

  task automatic test_timeout();
    logic e;
    ier = 2'b01; fcr_trig = 2'b10; counter_t = '1;
    for (int i = 0; i < 3; i++) fifo.push_back({8'(8'h30 + i), 3'b000});
    sync_fifo(); tick(); tick();
    n_checks++; if ({rda_int, ti_int} !== 2'b00) begin n_errors++; $display("FAIL ti_idle: got %b expected 00", {rda_int, ti_int}); end
    counter_t = '0; tick();
    n_checks++; if (ti_int !== 1'b1) begin n_errors++; $display("FAIL ti_set: got %b expected 1", ti_int); end
    tick();
    n_checks++; if (iir_id !== IIR_TI) begin n_errors++; $display("FAIL iir_ti: got %b expected 1100", iir_id); end
    rbr_read = 1'b1; counter_t = '1; exp_pop.push_back(rbr_read && fifo.size() != 0);
    tick(); rbr_read = 1'b0;
    e = exp_pop.pop_front();
    n_checks++; if (ti_int !== 1'b0) begin n_errors++; $display("FAIL ti_clear: got %b expected 0", ti_int); end
    n_checks++; if (rf_pop !== e) begin n_errors++; $display("FAIL ti_pop: got %b expected %b", rf_pop, e); end
    tick();
    n_checks++; if (iir_id !== IIR_NONE) begin n_errors++; $display("FAIL iir_none: got %b expected 0001", iir_id); end
    drain();
    counter_t = '0; tick(); tick();
    n_checks++; if (ti_int !== 1'b0) begin n_errors++; $display("FAIL ti_empty: got %b expected 0", ti_int); end
    counter_t = '1;
  endtask

  task automatic test_overrun();
    ier = 2'b10; thr_empty = 1'b0; tx_empty = 1'b1;
    rf_overrun = 1'b1; lsr_read = 1'b1; tick(); lsr_read = 1'b0;
    n_checks++; if (lsr !== 8'h42) begin n_errors++; $display("FAIL oe_set_wins: got %h expected 42", lsr); end
    n_checks++; if (lsr_mask !== 1'b1) begin n_errors++; $display("FAIL oe_mask: got %b expected 1", lsr_mask); end
    tick();
    n_checks++; if (lsr[LSR_OE] !== 1'b1 || ls_int !== 1'b1) begin n_errors++; $display("FAIL oe_hold: got oe %b ls %b expected 1 1", lsr[LSR_OE], ls_int); end
    tick();
    n_checks++; if (iir_id !== IIR_RLS) begin n_errors++; $display("FAIL oe_iir: got %b expected 0110", iir_id); end
    lsr_read = 1'b1; tick(); lsr_read = 1'b0;
    n_checks++; if (lsr[LSR_OE] !== 1'b0) begin n_errors++; $display("FAIL oe_clear: got %b expected 0", lsr[LSR_OE]); end
    rf_overrun = 1'b0; tick();
    n_checks++; if (lsr !== 8'h40 || ls_int !== 1'b0) begin n_errors++; $display("FAIL oe_final: got lsr %h ls %b expected 40 0", lsr, ls_int); end
    thr_empty = 1'b1; tx_empty = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic e;
    ier = 2'b00;
    fifo.push_back({8'h11, 3'b010});
    fifo.push_back({8'h22, 3'b001});
    fifo.push_back({8'h33, 3'b000});
    sync_fifo(); tick(); tick();
    n_checks++; if (lsr[4:1] !== 4'b0010) begin n_errors++; $display("FAIL pe_set: got %b expected 0010", lsr[4:1]); end
    for (int i = 0; i < 4; i++) begin
      rbr_read = (i < 3);
      exp_pop.push_back(rbr_read && fifo.size() != 0);
      tick();
      e = exp_pop.pop_front();
      n_checks++; if (rf_pop !== e) begin n_errors++; $display("FAIL b2b_pop%0d: got %b expected %b", i, rf_pop, e); end
    end
    rbr_read = 1'b0;
    n_checks++; if (lsr[4:1] !== 4'b0110) begin n_errors++; $display("FAIL fe_accum: got %b expected 0110", lsr[4:1]); end
    tick();
    n_checks++; if (lsr[LSR_DR] !== 1'b0 || lsr[4:1] !== 4'b0110) begin n_errors++; $display("FAIL b2b_empty: got %h expected dr 0 errs 0110", lsr); end
    lsr_read = 1'b1; tick(); lsr_read = 1'b0;
    n_checks++; if (lsr[4:1] !== 4'b0000) begin n_errors++; $display("FAIL b2b_clear: got %b expected 0000", lsr[4:1]); end
  endtask

  task automatic test_empty_read_and_reset();
    logic e;
    rbr_read = 1'b1; exp_pop.push_back(rbr_read && fifo.size() != 0);
    tick(); rbr_read = 1'b0;
    e = exp_pop.pop_front();
    n_checks++; if (rf_pop !== e) begin n_errors++; $display("FAIL empty_read: got %b expected %b", rf_pop, e); end
    ier = 2'b11; fcr_trig = 2'b00; rf_error_bit = 1'b1;
    fifo.push_back({8'h5a, 3'b100}); sync_fifo();
    tick(); tick(); tick();
    n_checks++; if (iir_id !== IIR_RLS) begin n_errors++; $display("FAIL pre_reset_iir: got %b expected 0110", iir_id); end
    wb_rst_i = 1'b1; #1;
    n_checks++; if (lsr !== 8'h20) begin n_errors++; $display("FAIL midrst_lsr: got %h expected 20", lsr); end
    n_checks++; if ({rf_pop, lsr_mask, rda_int, ti_int, ls_int} !== 5'b0) begin n_errors++; $display("FAIL midrst_outs: got %b expected 00000", {rf_pop, lsr_mask, rda_int, ti_int, ls_int}); end
    n_checks++; if (iir_id !== IIR_NONE) begin n_errors++; $display("FAIL midrst_iir: got %b expected 0001", iir_id); end
    tick(); wb_rst_i = 1'b0;
    tick();
    n_checks++; if (lsr[LSR_BI] !== 1'b0 || lsr[LSR_DR] !== 1'b1) begin n_errors++; $display("FAIL post_rst_first: got %h expected dr 1 bi 0", lsr); end
    tick();
    n_checks++; if (lsr[LSR_BI] !== 1'b1) begin n_errors++; $display("FAIL post_rst_topnew: got %b expected 1", lsr[LSR_BI]); end
    lsr_read = 1'b1; tick(); lsr_read = 1'b0;
    tick(); tick();
    n_checks++; if (lsr[LSR_BI] !== 1'b0) begin n_errors++; $display("FAIL post_rst_once: got %b expected 0", lsr[LSR_BI]); end
    rf_error_bit = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_data_ready();
    test_line_status();
    test_trigger();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_empty_read_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx_status.md
# uart_rx_status

Receive-side status and interrupt block, directly downstream of the UART receiver and its receive FIFO. Consumes FIFO occupancy, top-of-FIFO error flags, overrun and the character-timeout counter. Produces the Line Status Register (LSR), RX interrupt requests, the 16550 interrupt identification code, the FIFO pop strobe and the `lsr_mask` status-reset pulse fed back to the receiver.

## Interface
Parameters:
- `FIFO_CW`, default 5: `UART_FIFO_COUNTER_W`, the FIFO count width (depth 16).
- `REC_W`, default 11: `UART_FIFO_REC_WIDTH`, the record layout {data[7:0], break, parity_err, framing_err}.

Ports:
- `clk` in 1: clock.
- `wb_rst_i` in 1: asynchronous, active-high reset.
- `rf_count` in FIFO_CW: RX FIFO occupancy.
- `rf_data_out` in REC_W: top-of-FIFO record.
- `rf_overrun` in 1: FIFO overrun flag.
- `rf_error_bit` in 1: some FIFO entry carries an error.
- `counter_t` in 10: character-timeout counter; 0 means expired.
- `fcr_trig` in 2: RX trigger level. 00→1, 01→4, 10→8, 11→14.
- `ier` in 2: [0] ERBFI, [1] ELSI.
- `thr_empty`, `tx_empty` in 1: transmitter flags, passed to LSR[5], LSR[6].
- `lsr_read` in 1: one-cycle host read strobe of LSR.
- `rbr_read` in 1: one-cycle host read strobe of RBR.
- `rf_pop` out 1: FIFO pop pulse.
- `lsr_mask` out 1: status-reset pulse to the receiver and FIFO.
- `lsr` out 8: line status.
- `rda_int` out 1: received-data-available request.
- `ti_int` out 1: timeout request.
- `ls_int` out 1: line-status request.
- `iir_id` out 4: interrupt identification code.

## Operation
**Pop.**
- `rf_pop` is registered: it pulses 1 cycle after `rbr_read` when `rf_count != 0`.
- `rbr_read` with an empty FIFO produces no pop.

**New-top event.**
- `top_new` fires in the cycle after `rf_count` goes 0→nonzero.
- It also fires in the cycle after an `rf_pop` when `rf_count` is still nonzero.

**LSR bits:**
- [0] DR = `rf_count != 0`. Combinational from a registered count compare.
- [1] OE: sticky. Set on the rising edge of `rf_overrun`.
- [2] PE, [3] FE, [4] BI: sticky. On `top_new`, set if `rf_data_out` bit 1, 0 or 2 respectively is 1.
- [5], [6]: `thr_empty`, `tx_empty` passthrough.
- [7] = `rf_error_bit` gated by `rf_count != 0`.

**Clearing.**
- OE, PE, FE and BI clear in the cycle after `lsr_read`.
- A set event in the same cycle as the clear wins; the error is never lost.
- `lsr_mask` = `lsr_read` delayed 1 cycle, 1-cycle pulse.

**Interrupt requests:**
- `rda_int` = ERBFI & (`rf_count` ≥ trigger level). Registered.
- `ti_int` = ERBFI & (`counter_t == 0`) & (`rf_count != 0`). Set registered; cleared in the cycle after `rbr_read`, and when the FIFO empties.
- `ls_int` = ELSI & |lsr[4:1].

**Priority and `iir_id`** (registered):
- LS → 0110
- else RDA → 0100
- else TI → 1100
- else 0001 (no interrupt)

## Timing
- Reset values: `lsr[4:0]`=0, `lsr[7]`=0; `rf_pop`, `lsr_mask`, all `*_int` = 0; `iir_id` = 0001.
- Latencies:
  - Count change → DR: 1 cycle.
  - `top_new` → PE/FE/BI: 1 cycle. This gives 2 cycles from a FIFO edge to the LSR bit.
  - Interrupt request → `iir_id`: 1 cycle.
- Back-to-back `rbr_read` on consecutive cycles gives consecutive pops. Each pop is qualified by the count sampled at the strobe.
- Trigger 14 with `rf_count` = 16 (full) keeps `rda_int` asserted.
- `wb_rst_i` asserted mid-operation clears all state immediately. After deassertion, no spurious `top_new` is generated unless the count is nonzero at the first clock edge; in that case `top_new` fires once.

## Structure
- Shared package/defines (`uart_defines`):
  - `UART_FIFO_COUNTER_W`, `UART_FIFO_REC_WIDTH`
  - LSR bit indices (DR, OE, PE, FE, BI, THRE, TEMT, EI)
  - IIR codes (0001, 0110, 0100, 1100)
  - trigger-level encodings
- One natural sub-module: `uart_sticky_bit`. It is a set-priority sticky flag with synchronous clear and async reset, instantiated for OE, PE, FE and BI.
- Total RTL is about 180 lines.

## Test plan
- Push one record {8'h41, 3'b000} with ERBFI=1, trig=00 → DR=1 and `rda_int`=1 within 2 cycles; `iir_id`=0100. `rbr_read` → `rf_pop` pulses once; DR=0.
- Top record {8'h00, 3'b100}, ELSI=1 → LSR[4]=1, LSR[7]=1, `ls_int`=1, `iir_id`=0110. `lsr_read` → BI clears next cycle and `lsr_mask` pulses once.
- trig=10 with 7 entries → `rda_int`=0; 8th push → `rda_int`=1.
- 3 entries below trigger, `counter_t` driven to 0 → `ti_int`=1, `iir_id`=1100. `rbr_read` → `ti_int`=0.
- `rf_overrun` rising in the same cycle as `lsr_read` → OE=1 remains set; a second `lsr_read` clears it.
- `rbr_read` with `rf_count`=0 → no `rf_pop`. Assert `wb_rst_i` mid-sequence → all outputs at reset values, `iir_id`=0001.
